// File: rtl/cpu_pkg.sv
// Shared CPU types: address/data widths, fetch FSM states and the prefetch-queue entry.
package cpu_pkg;

   localparam int PC_W   = 6;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      SQUASH = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic [PC_W-1:0]   pc;
   } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory read port plus the valid/ready link to decode.
interface instr_fetch_if;
   import cpu_pkg::*;

   // Handshake: decode takes the head in any cycle where if_valid & id_ready are both high;
   // if_instr/if_pc are stable while if_valid & ~id_ready. Memory data returns one cycle after imem_req.
   logic [PC_W-1:0]   counter;
   logic              imem_req;
   logic [DATA_W-1:0] imem_rdata;
   logic              if_valid;
   logic [DATA_W-1:0] if_instr;
   logic [PC_W-1:0]   if_pc;
   logic              id_ready;

   modport master (
      output counter, imem_req, if_valid, if_instr, if_pc,
      input  imem_rdata, id_ready
   );

   modport slave (
      input  counter, imem_req, if_valid, if_instr, if_pc,
      output imem_rdata, id_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue of {instr, pc} entries; flush beats a same-cycle push, push and pop may coincide.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  fetch_entry_t     push_entry,
   input  logic             pop,
   output logic [CNT_W-1:0] count,
   output fetch_entry_t     head
);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) begin
            mem_d[wr_q] = push_entry;
            wr_d        = wr_q + 1'b1;
         end
         if (pop) begin
            rd_d = rd_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;
   assign head  = mem_q[rd_q];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, one-deep outstanding-read tracking, BOOT/RUN/SQUASH FSM, prefetch queue.
// Optional IF_STALL_CNT_EN adds an 8-bit saturating count of memen cycles that could not issue.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memen,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirect_pc,
`ifdef IF_STALL_CNT_EN
   output logic [7:0]        stall_cnt,
`endif
   output fetch_state_t      dbg_state,
   instr_fetch_if.master     bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   fetch_state_t     state_q, state_d;
   logic [PC_W-1:0]  counter_q, counter_d;
   logic [PC_W-1:0]  pend_pc_q, pend_pc_d;
   logic             pending_q, pending_d;
   logic [CNT_W-1:0] count;
   fetch_entry_t     head;
   logic             if_valid, pop, push, req;
   logic [CNT_W:0]   occupancy;

   assign if_valid  = (count != '0);
   assign pop       = if_valid & bus.id_ready & ~redirect;
   assign push      = pending_q & (state_q != SQUASH) & ~redirect;
   // Slots already promised to the queue, counting the in-flight read and this cycle's pop.
   assign occupancy = {1'b0, count} + (CNT_W + 1)'(pending_q) - (CNT_W + 1)'(if_valid & bus.id_ready);
   assign req       = (state_q == RUN) & memen & ~redirect & (occupancy < (CNT_W + 1)'(DEPTH));

   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      pend_pc_d = pend_pc_q;
      pending_d = req;
      if (req) begin
         counter_d = counter_q + 1'b1;
         pend_pc_d = counter_q;
      end
      if (redirect) begin
         counter_d = redirect_pc;
      end
      case (state_q)
         BOOT:    if (!redirect) state_d = RUN;
         RUN:     if (redirect && pending_q) state_d = SQUASH;
         SQUASH:  state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= BOOT;
         counter_q <= '0;
         pend_pc_q <= '0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         pend_pc_q <= pend_pc_d;
         pending_q <= pending_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (reset),
      .flush      (redirect),
      .push       (push),
      .push_entry ('{instr: bus.imem_rdata, pc: pend_pc_q}),
      .pop        (pop),
      .count      (count),
      .head       (head)
   );

`ifdef IF_STALL_CNT_EN
   logic [7:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (redirect) begin
         stall_d = '0;
      end else if ((state_q == RUN) && memen && !req && (stall_q != 8'hFF)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stall_q <= '0;
      else        stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`endif

   assign dbg_state    = state_q;
   assign bus.counter  = counter_q;
   assign bus.imem_req = req;
   assign bus.if_valid = if_valid;
   assign bus.if_instr = head.instr;
   assign bus.if_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic against a queue-based fetch model.
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam int DEPTH = 2;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic memen = 1'b0;
  logic redirect = 1'b0;
  logic [PC_W-1:0] redirect_pc = '0;
  fetch_state_t dbg_state;
`ifdef IF_STALL_CNT_EN
  logic [7:0] stall_cnt;
`endif

  instr_fetch_if bus();

  instr_fetch #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .memen       (memen),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
`ifdef IF_STALL_CNT_EN
    .stall_cnt   (stall_cnt),
`endif
    .dbg_state   (dbg_state),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;

  // model: queue of {instr, pc}, PC, outstanding read, mode 0=boot 1=run 2=squash
  logic [DATA_W+PC_W-1:0] exp_q[$];
  int m_pc, m_ppc, m_mode, m_stall;
  bit m_pend;

  // observations of the DUT for the literal pins
  int cyc, first_req_cyc, req_obs;
  logic [PC_W-1:0]   pc_log[$];
  logic [DATA_W-1:0] ins_log[$];
  int pop_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input int a);
    return DATA_W'(32'h1000_0000 + a);
  endfunction

  function automatic fetch_state_t mode_state(input int m);
    if (m == 0) return BOOT;
    if (m == 2) return SQUASH;
    return RUN;
  endfunction

  task automatic clear_logs();
    pc_log.delete();
    ins_log.delete();
    pop_cyc.delete();
    first_req_cyc = -1;
    req_obs = 0;
  endtask

  // ---------------- driver tasks ----------------
  // Called right after a falling edge; returns on the next falling edge.
  task automatic step(input bit me, input bit rd, input int rp, input bit ir);
    bit exp_valid, exp_req, pop;
    int occ;
    memen       = me;
    redirect    = rd;
    redirect_pc = PC_W'(rp);
    bus.id_ready = ir;
    bus.imem_rdata = m_pend ? mem_word(m_ppc) : DATA_W'($urandom);
    #1;
    exp_valid = (exp_q.size() > 0);
    pop       = exp_valid && ir;
    occ       = exp_q.size() + int'(m_pend) - int'(pop);
    exp_req   = (m_mode == 1) && me && !rd && (occ < DEPTH);

    chk("counter",  64'(bus.counter),  64'(m_pc));
    chk("imem_req", 64'(bus.imem_req), 64'(exp_req));
    chk("if_valid", 64'(bus.if_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk("if_instr", 64'(bus.if_instr), 64'(exp_q[0][PC_W +: DATA_W]));
      chk("if_pc",    64'(bus.if_pc),    64'(exp_q[0][PC_W-1:0]));
    end
    chk("state", 64'(dbg_state), 64'(mode_state(m_mode)));
`ifdef IF_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif

    if (bus.imem_req) begin
      req_obs++;
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (bus.if_valid && ir && !rd) begin
      pc_log.push_back(bus.if_pc);
      ins_log.push_back(bus.if_instr);
      pop_cyc.push_back(cyc);
    end

    if (rd) begin
      exp_q.delete();
      m_pc    = rp % (2 ** PC_W);
      m_mode  = (m_mode == 0) ? 0 : ((m_mode == 1 && m_pend) ? 2 : 1);
      m_pend  = 1'b0;
      m_stall = 0;
    end else begin
      if (m_mode == 1 && me && !exp_req) m_stall = (m_stall < 255) ? m_stall + 1 : 255;
      if (pop) void'(exp_q.pop_front());
      if (m_pend && m_mode != 2) exp_q.push_back({mem_word(m_ppc), PC_W'(m_ppc)});
      if (exp_req) begin
        m_ppc  = m_pc;
        m_pc   = (m_pc + 1) % (2 ** PC_W);
        m_pend = 1'b1;
      end else begin
        m_pend = 1'b0;
      end
      m_mode = 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Asserts reset wherever it is called, checks the asynchronous clear, releases on a falling edge.
  task automatic do_reset();
    reset = 1'b0;
    memen = 1'b0;
    redirect = 1'b0;
    bus.id_ready = 1'b0;
    #1;
    chk("rst_counter",  64'(bus.counter),  64'd0);
    chk("rst_imem_req", 64'(bus.imem_req), 64'd0);
    chk("rst_if_valid", 64'(bus.if_valid), 64'd0);
    chk("rst_if_instr", 64'(bus.if_instr), 64'd0);
    chk("rst_if_pc",    64'(bus.if_pc),    64'd0);
    chk("rst_state",    64'(dbg_state),    64'(BOOT));
    exp_q.delete();
    m_pc = 0; m_ppc = 0; m_mode = 0; m_stall = 0; m_pend = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    clear_logs();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    bus.imem_rdata = '0;
    bus.id_ready = 1'b0;
    do_reset();

    // Toggling memen, decode always ready: BOOT, first request cycle 2, one instr per 2 cycles.
    for (int i = 0; i < 20; i++) step(i % 2 == 0, 1'b0, 0, 1'b1);
    chk("a_first_req_cycle", 64'(first_req_cyc), 64'd2);
    chk("a_pops_ge4", 64'(pc_log.size() >= 4), 64'd1);
    chk("a_first_pop_cycle", 64'(pop_cyc[0]), 64'd4);
    chk("a_pop_gap", 64'(pop_cyc[1] - pop_cyc[0]), 64'd2);
    for (int i = 0; i < 4; i++) begin
      chk("a_pc_seq",    64'(pc_log[i]),  64'(i));
      chk("a_instr_seq", 64'(ins_log[i]), 64'(32'h1000_0000 + i));
    end

    // Decode stalled: exactly DEPTH requests, head at pc 0 held, then in-order drain.
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 0, 1'b0);
    chk("b_stalled_reqs", 64'(req_obs), 64'(DEPTH));
    chk("b_head_valid", 64'(bus.if_valid), 64'd1);
    chk("b_head_pc",    64'(bus.if_pc),    64'd0);
    chk("b_req_idle",   64'(bus.imem_req), 64'd0);
    clear_logs();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 0, 1'b1);
    chk("b_drain_count", 64'(pc_log.size()), 64'd2);
    chk("b_drain_0", 64'(pc_log[0]), 64'd0);
    chk("b_drain_1", 64'(pc_log[1]), 64'd1);

    // PC wrap through 63 -> 0.
    step(1'b0, 1'b1, 62, 1'b1);
    clear_logs();
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 0, 1'b1);
    chk("c_pops_ge4", 64'(pc_log.size() >= 4), 64'd1);
    chk("c_pc_0", 64'(pc_log[0]), 64'd62);
    chk("c_pc_1", 64'(pc_log[1]), 64'd63);
    chk("c_pc_2", 64'(pc_log[2]), 64'd0);
    chk("c_pc_3", 64'(pc_log[3]), 64'd1);

    // Redirect in the response cycle: SQUASH, queue empty, refetch from 0x20.
    k = 0;
    while (!m_pend && k < 10) begin
      step(1'b1, 1'b0, 0, 1'b1);
      k++;
    end
    chk("d_pending_found", 64'(m_pend), 64'd1);
    step(1'b1, 1'b1, 'h20, 1'b1);
    chk("d_state_squash", 64'(dbg_state),    64'(SQUASH));
    chk("d_valid_drop",   64'(bus.if_valid), 64'd0);
    clear_logs();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0, 1'b1);
    chk("d_first_pc",    64'(pc_log[0]),  64'h20);
    chk("d_first_instr", 64'(ins_log[0]), 64'h1000_0020);

    // Reset while a read is outstanding: no stale push, fetch restarts at 0.
    k = 0;
    while (!m_pend && k < 10) begin
      step(1'b1, 1'b0, 0, 1'b1);
      k++;
    end
    chk("e_pending_found", 64'(m_pend), 64'd1);
    #2;
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0, 1'b1);
    chk("e_first_pc",    64'(pc_log[0]),  64'd0);
    chk("e_first_instr", 64'(ins_log[0]), 64'h1000_0000);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
           int'($urandom_range(0, 63)), $urandom_range(0, 3) != 0);

`ifdef IF_STALL_CNT_EN
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 0, 1'b0);
    chk("g_stall_sat", 64'(stall_cnt), 64'd255);
    step(1'b1, 1'b1, 5, 1'b0);
    chk("g_stall_clr", 64'(stall_cnt), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: sequence did not complete, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
